// File: rtl/rptr_empty_level.sv
// rptr_empty_level: read-side async FIFO pointer with empty, almost-empty, level and underflow flags.
// Write pointer is Gray-synchronised into rclk; every flag is registered from the next-state read pointer.
module rptr_empty_level #(
    parameter int ADDRSIZE    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AE_THRESH   = 2
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic [ADDRSIZE:0]   wptr,
    input  logic                rinc,
    input  logic                rclr_err,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic                ralmost_empty,
    output logic [ADDRSIZE:0]   rlevel,
    output logic                runderflow
);
    localparam logic [ADDRSIZE:0] AE = (ADDRSIZE+1)'(AE_THRESH);

    logic [ADDRSIZE:0] wq [SYNC_STAGES];
    logic [ADDRSIZE:0] wq_sync, wbin_sync;
    logic [ADDRSIZE:0] rbin, rbinnext, rgraynext, rdiff;

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) wq[i] <= '0;
        end else begin
            wq[0] <= wptr;
            for (int i = 1; i < SYNC_STAGES; i++) wq[i] <= wq[i-1];
        end
    end

    assign wq_sync = wq[SYNC_STAGES-1];

    for (genvar g = 0; g <= ADDRSIZE; g++) begin : g_g2b
        assign wbin_sync[g] = ^(wq_sync >> g);
    end

    // Modulo subtraction keeps the level correct across pointer wrap; a full FIFO gives 2^ADDRSIZE.
    assign rbinnext  = rbin + (ADDRSIZE+1)'(rinc & ~rempty);
    assign rgraynext = (rbinnext >> 1) ^ rbinnext;
    assign rdiff     = wbin_sync - rbinnext;
    assign raddr     = rbin[ADDRSIZE-1:0];

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            rbin          <= '0;
            rptr          <= '0;
            rempty        <= 1'b1;
            ralmost_empty <= 1'b1;
            rlevel        <= '0;
            runderflow    <= 1'b0;
        end else begin
            rbin          <= rbinnext;
            rptr          <= rgraynext;
            rempty        <= rgraynext == wq_sync;
            ralmost_empty <= rdiff <= AE;
            rlevel        <= rdiff;
            runderflow    <= (rinc & rempty) | (runderflow & ~rclr_err);
        end
    end
endmodule

// File: tb/tb_rptr_empty_level.sv
// tb_rptr_empty_level: scoreboard bench; stimulus pushes expected outputs, a negedge monitor compares.
// Reference tracks write/read counts as plain integers and a delay queue for the synchroniser.
module tb_rptr_empty_level;
    localparam int A = 4, S = 2, AET = 2, M = 32, D = 16;

    logic           rclk = 0, rrst_n = 0, rinc = 0, rclr_err = 0;
    logic [A:0]     wptr = '0;
    logic [A-1:0]   raddr;
    logic [A:0]     rptr, rlevel;
    logic           rempty, ralmost_empty, runderflow;

    rptr_empty_level #(.ADDRSIZE(A), .SYNC_STAGES(S), .AE_THRESH(AET)) dut (
        .rclk(rclk), .rrst_n(rrst_n), .wptr(wptr), .rinc(rinc), .rclr_err(rclr_err),
        .raddr(raddr), .rptr(rptr), .rempty(rempty), .ralmost_empty(ralmost_empty),
        .rlevel(rlevel), .runderflow(runderflow)
    );

    always #5 rclk = ~rclk;

    typedef struct {
        int raddr; int rptr; int level; bit empty; bit ae; bit uf; bit acc;
    } exp_t;

    exp_t sb[$];
    int   hist[$];
    int   wcnt = 0, rtot = 0, checks = 0, errors = 0;
    bit   m_empty = 1, m_uf = 0;
    logic [A:0] prev_rptr = '0;

    function automatic logic [A:0] gray(int b);
        return (A+1)'(b ^ (b >> 1));
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(bit rst, bit ri, bit clr);
        exp_t e;
        int ws, lvl;
        rrst_n = !rst; rinc = ri; rclr_err = clr; wptr = gray(wcnt % M);
        if (rst) begin
            hist.delete();
            repeat (S) hist.push_back(0);
            rtot = 0; m_empty = 1; m_uf = 0;
            e = '{raddr: 0, rptr: 0, level: 0, empty: 1, ae: 1, uf: 0, acc: 0};
        end else begin
            ws = hist.pop_front();
            hist.push_back(wcnt % M);
            e.acc = ri && !m_empty;
            m_uf  = (ri && m_empty) || (m_uf && !clr);
            rtot += int'(e.acc);
            lvl = ((ws - rtot) % M + M) % M;
            m_empty = lvl == 0;
            e.raddr = rtot % D;
            e.rptr  = int'(gray(rtot % M));
            e.level = lvl;
            e.empty = m_empty;
            e.ae    = lvl <= AET;
            e.uf    = m_uf;
        end
        sb.push_back(e);
        @(posedge rclk);
        #1;
    endtask

    always @(negedge rclk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("raddr", 32'(raddr), e.raddr);
            chk("rptr", 32'(rptr), e.rptr);
            chk("rlevel", 32'(rlevel), e.level);
            chk("rempty", 32'(rempty), 32'(e.empty));
            chk("ralmost_empty", 32'(ralmost_empty), 32'(e.ae));
            chk("runderflow", 32'(runderflow), 32'(e.uf));
            if (e.acc) chk("rptr_hamming", $countones(prev_rptr ^ rptr), 1);
            prev_rptr = rptr;
        end
    end

    initial begin
        repeat (S) hist.push_back(0);
        // reset with rinc asserted
        step(1, 1, 0); step(1, 1, 0);
        // fill to 5, observe sync latency
        wcnt = 5;
        repeat (3) step(0, 0, 0);
        // drain 5, then underflow
        repeat (5) step(0, 1, 0);
        step(0, 1, 0);
        // clear: set wins, then clear alone
        step(0, 1, 1);
        step(0, 0, 1);
        step(0, 0, 0);
        // full FIFO from reset
        wcnt = 0; step(1, 0, 0);
        wcnt = 16;
        repeat (3) step(0, 0, 0);
        // stream with wrap against advancing writer
        for (int g = 0; g < 400 && rtot < 40; g++) begin
            if ($urandom_range(0, 1) == 1 && wcnt - rtot < D) wcnt++;
            step(0, $urandom_range(0, 3) != 0, 0);
        end
        // reset mid-drain at level 3
        wcnt = 0; step(1, 0, 0);
        wcnt = 8;
        repeat (3) step(0, 0, 0);
        repeat (5) step(0, 1, 0);
        step(1, 1, 1);
        repeat (4) step(0, 1, 0);
        // random tail
        for (int g = 0; g < 80; g++) begin
            if ($urandom_range(0, 2) != 0 && wcnt - rtot < D) wcnt++;
            step(0, $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0);
        end
        @(negedge rclk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rptr_empty_level.md
RPTR_EMPTY_LEVEL -- requirements
Module: rptr_empty_level

Interface
REQ-001 SHALL have parameter ADDRSIZE, default 4, memory address width; depth 2^ADDRSIZE; legal range >= 2.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of write-pointer synchroniser flops; legal range >= 2.
REQ-003 SHALL have parameter AE_THRESH, default 2, almost-empty level threshold; legal range 0..2^ADDRSIZE.
REQ-004 SHALL have port rclk  input  1  read-domain clock; all flops on rising edge.
REQ-005 SHALL have port rrst_n  input  1  reset, synchronous to rclk, active-low.
REQ-006 SHALL have port wptr  input  ADDRSIZE+1  Gray write pointer, asynchronous to rclk.
REQ-007 SHALL have port rinc  input  1  read request.
REQ-008 SHALL have port rclr_err  input  1  clears the sticky underflow flag.
REQ-009 SHALL have port raddr  output  ADDRSIZE  binary memory read address.
REQ-010 SHALL have port rptr  output  ADDRSIZE+1  registered Gray read pointer, for the write domain.
REQ-011 SHALL have port rempty  output  1  registered empty flag.
REQ-012 SHALL have port ralmost_empty  output  1  registered almost-empty flag.
REQ-013 SHALL have port rlevel  output  ADDRSIZE+1  registered occupancy, read-domain view.
REQ-014 SHALL have port runderflow  output  1  sticky read-while-empty error flag.

Function
REQ-015 SHALL pass wptr through SYNC_STAGES cascaded flops; only the last stage (wq_sync) is used downstream.
REQ-016 SHALL convert wq_sync from Gray to binary (wbin_sync) combinationally: bit i = XOR of bits ADDRSIZE..i.
REQ-017 SHALL hold binary read counter rbin (ADDRSIZE+1 bits); rbinnext = rbin + (rinc & ~rempty), modulo 2^(ADDRSIZE+1).
REQ-018 SHALL compute rgraynext = (rbinnext >> 1) ^ rbinnext; register rbin <= rbinnext, rptr <= rgraynext every edge.
REQ-019 SHALL drive raddr = rbin[ADDRSIZE-1:0]; raddr, rptr change only on accepted reads.
REQ-020 SHALL register rempty <= (rgraynext == wq_sync).
REQ-021 SHALL register rlevel <= wbin_sync - rbinnext, modulo 2^(ADDRSIZE+1); full FIFO reports 2^ADDRSIZE, no truncation.
REQ-022 SHALL register ralmost_empty <= (wbin_sync - rbinnext) <= AE_THRESH, unsigned compare.
REQ-023 SHALL treat rinc with rempty=1 as underflow: pointers unchanged, runderflow set on next edge.
REQ-024 SHALL clear runderflow on edge with rclr_err=1; set wins over clear in the same cycle.
REQ-025 SHALL give latency: wptr change stable before edge N updates rempty/rlevel/ralmost_empty at edge N+SYNC_STAGES; accepted read updates them at the same edge as rptr.
REQ-026 SHALL wrap rbin from 2^(ADDRSIZE+1)-1 to 0; rptr changes exactly one bit per accepted read, including at wrap.
REQ-027 SHALL NOT change rempty/rlevel polarity or value on pointer wrap; equality and subtraction are wrap-safe.

Reset
REQ-028 SHALL, on edge with rrst_n=0, load rbin=0, rptr=0, all sync flops=0, rempty=1, ralmost_empty=1, rlevel=0, runderflow=0; raddr=0.
REQ-029 SHALL give reset priority over rinc and rclr_err, including mid-drain; first post-reset edge behaves as from empty.

Verification (ADDRSIZE=4, SYNC_STAGES=2, AE_THRESH=2)
REQ-030 SHALL cover reset: rrst_n=0 two edges with rinc=1 -> rempty=1, ralmost_empty=1, rlevel=0, rptr=0, raddr=0, runderflow=0.
REQ-031 SHALL cover fill latency: wptr=5'b00111 (bin 5) from edge 0 -> rempty=0, rlevel=5, ralmost_empty=0 after edge 2, not before.
REQ-032 SHALL cover drain: then rinc=1 for 5 edges -> raddr 0,1,2,3,4 then 5; rlevel 4,3,2,1,0; ralmost_empty=1 from level 2; rempty=1 after 5th edge; 6th rinc -> runderflow=1, rptr stays 5'b00111.
REQ-033 SHALL cover error clear: rclr_err=1 with rinc=1 on empty -> runderflow stays 1; rclr_err=1, rinc=0 -> 0 next edge.
REQ-034 SHALL cover full and wrap: wptr=gray(16) with rptr=0 -> rlevel=16, rempty=0; stream 40 reads against advancing wptr -> rptr Hamming distance 1 per read, rbin wraps 31->0, rlevel never exceeds 16.
REQ-035 SHALL cover reset mid-drain: rrst_n=0 one edge at rlevel=3 -> all outputs at REQ-028 values next edge.
